// File: rtl/con_logic_prims.sv
// con_logic_prims: MECL-style primitives used to build CON control logic.
//   - 4-bit universal shift register (load / shift right / shift left / hold)
//   - 3-to-8 one-hot decoder with enable
//   - MUX_N-to-1 mux with enable (disabled output is 0, so outputs can be OR-tied)
// All vectors are big-endian: index 0 is the MSB.
// Optional build macro USR_CASCADE_EN adds the serial-out taps usr_sout_r and
// usr_sout_l, which are used to chain two shift registers into an 8-bit shifter.
module con_logic_prims #(
    parameter int MUX_N = 8
) (
    input  logic                           clk,
    input  logic                           reset_n,
    input  logic [0:1]                     usr_sel,
    input  logic                           usr_s0,
    input  logic                           usr_s3,
    input  logic [0:3]                     usr_d,
    output logic [0:3]                     usr_q,
`ifdef USR_CASCADE_EN
    output logic                           usr_sout_r,
    output logic                           usr_sout_l,
`endif
    input  logic                           dec_en,
    input  logic [0:2]                     dec_sel,
    output logic [0:7]                     dec_q,
    input  logic                           mux_en,
    input  logic [0:$clog2(MUX_N)-1]       mux_sel,
    input  logic [0:MUX_N-1]               mux_d,
    output logic                           mux_q
);

    localparam int MUX_SW = $clog2(MUX_N);

    localparam logic [0:1] USR_LOAD  = 2'b00;
    localparam logic [0:1] USR_SHR   = 2'b01;
    localparam logic [0:1] USR_SHL   = 2'b10;

    // Shift register: reset dominates, then the mode select picks the next contents.
    always_ff @(posedge clk) begin
        if (!reset_n) begin
            usr_q <= 4'b0000;
        end else begin
            case (usr_sel)
                USR_LOAD: usr_q <= usr_d;
                USR_SHR:  usr_q <= {usr_s0, usr_q[0:2]};
                USR_SHL:  usr_q <= {usr_q[1:3], usr_s3};
                default:  usr_q <= usr_q;
            endcase
        end
    end

`ifdef USR_CASCADE_EN
    // Serial-out taps: the bit that a shift in each direction would push out.
    assign usr_sout_r = usr_q[3];
    assign usr_sout_l = usr_q[0];
`endif

    // Decoder: one-hot on the selected output when enabled, otherwise all zeros.
    always_comb begin
        dec_q = 8'b0000_0000;
        if (dec_en) begin
            dec_q[dec_sel] = 1'b1;
        end
    end

    // Mux: only the selected input reaches the output, gated by the enable.
    always_comb begin
        mux_q = 1'b0;
        if (mux_en) begin
            mux_q = mux_d[mux_sel[0:MUX_SW-1]];
        end
    end

endmodule

// File: tb/tb_con_logic_prims.sv
// tb_con_logic_prims: randomized and directed bench for con_logic_prims with an
// arithmetic reference model (vectors treated as numbers, index 0 = MSB).
module tb_con_logic_prims;

    localparam int MUX_N  = 8;
    localparam int MUX_SW = $clog2(MUX_N);

    logic              clk = 1'b0;
    logic              reset_n;
    logic [0:1]        usr_sel;
    logic              usr_s0;
    logic              usr_s3;
    logic [0:3]        usr_d;
    logic [0:3]        usr_q;
    logic              dec_en;
    logic [0:2]        dec_sel;
    logic [0:7]        dec_q;
    logic              mux_en;
    logic [0:MUX_SW-1] mux_sel;
    logic [0:MUX_N-1]  mux_d;
    logic              mux_q;
`ifdef USR_CASCADE_EN
    logic              usr_sout_r;
    logic              usr_sout_l;
`endif

    int n_checks = 0;
    int n_pass   = 0;

    // Reference model state: shift register value as a plain number (Q[0] = weight 8).
    int  m_val   = 0;
    bit  m_valid = 1'b0;
    bit  done    = 1'b0;

    con_logic_prims #(.MUX_N(MUX_N)) dut (
        .clk       (clk),
        .reset_n   (reset_n),
        .usr_sel   (usr_sel),
        .usr_s0    (usr_s0),
        .usr_s3    (usr_s3),
        .usr_d     (usr_d),
        .usr_q     (usr_q),
`ifdef USR_CASCADE_EN
        .usr_sout_r(usr_sout_r),
        .usr_sout_l(usr_sout_l),
`endif
        .dec_en    (dec_en),
        .dec_sel   (dec_sel),
        .dec_q     (dec_q),
        .mux_en    (mux_en),
        .mux_sel   (mux_sel),
        .mux_d     (mux_d),
        .mux_q     (mux_q)
    );

    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [15:0] got, input logic [15:0] exp);
        n_checks++;
        if (got === exp) n_pass++;
        else $display("FAIL %s: got %0h expected %0h at %0t", name, got, exp, $time);
    endtask

    // Reference model: advance the shift-register value on each rising edge.
    always @(posedge clk) begin
        if (reset_n === 1'b0) begin
            m_val   = 0;
            m_valid = 1'b1;
        end else if (m_valid) begin
            case (int'(usr_sel))
                0: m_val = int'(usr_d);
                1: m_val = (int'(usr_s0) * 8) + (m_val / 2);
                2: m_val = ((m_val * 2) % 16) + int'(usr_s3);
                default: m_val = m_val;
            endcase
        end
    end

    // Compare process: mid-cycle check of every output against the model.
    always @(negedge clk) begin
        int exp_dec;
        int exp_mux;
        if (!done) begin
            exp_dec = dec_en ? (128 >> int'(dec_sel)) : 0;
            exp_mux = mux_en ? ((int'(mux_d) >> (MUX_N - 1 - int'(mux_sel))) % 2) : 0;
            chk("model_dec", 16'(dec_q), 16'(exp_dec));
            chk("model_mux", 16'(mux_q), 16'(exp_mux));
            if (m_valid) begin
                chk("model_usr", 16'(usr_q), 16'(m_val));
`ifdef USR_CASCADE_EN
                chk("model_sout_r", 16'(usr_sout_r), 16'(m_val % 2));
                chk("model_sout_l", 16'(usr_sout_l), 16'(m_val / 8));
`endif
            end
        end
    end

    task automatic set_usr(input logic rn, input logic [0:1] sel, input logic [0:3] d,
                           input logic s0, input logic s3);
        reset_n = rn; usr_sel = sel; usr_d = d; usr_s0 = s0; usr_s3 = s3;
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    initial begin
        logic [0:7] mux_pattern;
        logic [0:7] mux_expect;
        set_usr(1'b0, 2'b00, 4'b1010, 1'b0, 1'b0);
        dec_en = 1'b0; dec_sel = 3'd0;
        mux_en = 1'b0; mux_sel = '0; mux_d = '0;

        // Reset, load, hold.
        tick(); chk("reset", 16'(usr_q), 16'b0000);
        set_usr(1'b1, 2'b00, 4'b1010, 1'b0, 1'b0);
        tick(); chk("load_1010", 16'(usr_q), 16'b1010);
        set_usr(1'b1, 2'b11, 4'b0101, 1'b1, 1'b1);
        for (int i = 0; i < 3; i++) begin
            tick(); chk("hold", 16'(usr_q), 16'b1010);
        end

        // Shift right with S0=1, then shift left with S3=0.
        set_usr(1'b1, 2'b01, 4'b0000, 1'b1, 1'b1);
        tick(); chk("shr1", 16'(usr_q), 16'b1101);
        tick(); chk("shr2", 16'(usr_q), 16'b1110);
        set_usr(1'b1, 2'b10, 4'b0000, 1'b1, 1'b0);
        tick(); chk("shl1", 16'(usr_q), 16'b1100);
        tick(); chk("shl2", 16'(usr_q), 16'b1000);

        // Reset mid-shift, then continue shifting from zero.
        set_usr(1'b0, 2'b01, 4'b1111, 1'b1, 1'b1);
        tick(); chk("reset_mid", 16'(usr_q), 16'b0000);
        set_usr(1'b1, 2'b01, 4'b1111, 1'b1, 1'b1);
        tick(); chk("shr_after_reset", 16'(usr_q), 16'b1000);
        set_usr(1'b1, 2'b10, 4'b0000, 1'b0, 1'b1);
        tick(); chk("shl_in_s3", 16'(usr_q), 16'b0001);

        // Decoder sweep, enabled and disabled.
        set_usr(1'b1, 2'b11, 4'b0000, 1'b0, 1'b0);
        for (int i = 0; i < 8; i++) begin
            dec_en = 1'b1; dec_sel = 3'(i);
            #1; chk("dec_on", 16'(dec_q), 16'(8'b1000_0000 >> i));
            dec_en = 1'b0;
            #1; chk("dec_off", 16'(dec_q), 16'b0);
        end

        // Mux sweep with the documented pattern.
        mux_pattern = 8'b1011_0010;
        mux_expect  = 8'b1011_0010;
        mux_d = mux_pattern;
        for (int i = 0; i < MUX_N; i++) begin
            mux_sel = MUX_SW'(i);
            mux_en  = 1'b1;
            #1; chk("mux_on", 16'(mux_q), 16'(mux_expect[i]));
            mux_en  = 1'b0;
            #1; chk("mux_off", 16'(mux_q), 16'b0);
        end

`ifdef USR_CASCADE_EN
        // Cascade taps.
        set_usr(1'b1, 2'b00, 4'b1001, 1'b0, 1'b0);
        tick();
        chk("casc_load", 16'(usr_q), 16'b1001);
        chk("casc_sout_l1", 16'(usr_sout_l), 16'b1);
        chk("casc_sout_r1", 16'(usr_sout_r), 16'b1);
        set_usr(1'b1, 2'b01, 4'b0000, 1'b0, 1'b0);
        tick();
        chk("casc_shr", 16'(usr_q), 16'b0100);
        chk("casc_sout_l0", 16'(usr_sout_l), 16'b0);
        chk("casc_sout_r0", 16'(usr_sout_r), 16'b0);
`endif

        // Randomized phase: all three functions driven independently each cycle.
        for (int c = 0; c < 400; c++) begin
            @(posedge clk);
            #1;
            reset_n = ($urandom_range(0, 15) != 0);
            usr_sel = 2'($urandom_range(0, 3));
            usr_d   = 4'($urandom);
            usr_s0  = 1'($urandom);
            usr_s3  = 1'($urandom);
            dec_en  = 1'($urandom);
            dec_sel = 3'($urandom);
            mux_en  = 1'($urandom);
            mux_sel = MUX_SW'($urandom);
            mux_d   = MUX_N'($urandom);
        end

        @(posedge clk);
        @(negedge clk);
        #1;
        done = 1'b1;
        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
